punt_cycle_sequencer: RTL and testbench

Synchronous sequencer for punted CPU bus cycles on the CD32 USB riser. Accepts the RTC, joystick and button address-decode requests for the current CPU cycle and forwards exactly one of them to the MCU on a request line. It waits for the MCU acknowledge edge, or for a timeout, then drives DSACK until the CPU ends the cycle. It replaces the free-running ack/DSACK logic in the top level so that every punted cycle terminates and no request is left asserted.

---
 rtl/punt_cycle_sequencer.sv | 138 +++++++++++++
 tb/tb_punt_cycle_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/punt_cycle_sequencer.sv
// punt_cycle_sequencer: forwards one qualified punted CPU cycle to the MCU,
// waits for the MCU ack edge (or a timeout), then drives DSACK until the
// CPU ends the cycle. All outputs are registered.
module punt_cycle_sequencer #(
    parameter int         TIMEOUT   = 200,
    parameter logic [1:0] DSACK_VAL = 2'b10
) (
    input  logic       CLKCPU_A,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       PUNT_IN,
    input  logic       ENABLE,
    input  logic       DEC_RTC,
    input  logic       DEC_JOY,
    input  logic       DEC_BTN,
    input  logic       MCU_ACK,
    output logic       REQ_RTC,
    output logic       REQ_JOY,
    output logic       REQ_BTN,
    output logic [1:0] DSACK_OUT,
    output logic       DSACK_OE,
    output logic       BUSY,
    output logic       TIMEOUT_P
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, TERM} state_t;

    // Last counter value before a forced termination.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_n;
    logic [2:0] sel, sel_n;          // one-hot {rtc, btn, joy}, latched on accept
    logic [7:0] cnt, cnt_n;
    logic       oe, oe_n;
    logic [1:0] dout, dout_n;
    logic       busy, busy_n;
    logic       tp, tp_n;
    logic [2:0] ack_sync;            // s0 = [0], s1 = [1], s2 = [2]

    logic rtc_q, joy_q, btn_q, ack_rise;

    // Joystick and button requests only exist while the MCU is enabled.
    assign rtc_q    = DEC_RTC;
    assign joy_q    = DEC_JOY & ENABLE;
    assign btn_q    = DEC_BTN & ENABLE;
    assign ack_rise = ack_sync[1] & ~ack_sync[2];

    // Bring the asynchronous MCU ack into the CPU clock domain.
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) ack_sync <= 3'b000;
        else       ack_sync <= {ack_sync[1:0], MCU_ACK};
    end

    // State and output registers.
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            state <= IDLE;
            sel   <= 3'b000;
            cnt   <= 8'd0;
            oe    <= 1'b0;
            dout  <= 2'b11;
            busy  <= 1'b0;
            tp    <= 1'b0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            oe    <= oe_n;
            dout  <= dout_n;
            busy  <= busy_n;
            tp    <= tp_n;
        end
    end

    // Next state and next registered outputs; abort beats ack beats timeout.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        oe_n    = oe;
        dout_n  = dout;
        busy_n  = busy;
        tp_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!AS20 && PUNT_IN && (rtc_q || btn_q || joy_q)) begin
                    state_n = WAIT_ACK;
                    sel_n   = rtc_q ? 3'b100 : (btn_q ? 3'b010 : 3'b001);
                    busy_n  = 1'b1;
                    cnt_n   = 8'd0;
                end
            end
            WAIT_ACK: begin
                if (AS20) begin
                    state_n = IDLE;
                    sel_n   = 3'b000;
                    busy_n  = 1'b0;
                end else if (ack_rise) begin
                    state_n = TERM;
                    oe_n    = 1'b1;
                    dout_n  = DSACK_VAL;
                end else if (cnt == CNT_LAST) begin
                    state_n = TERM;
                    oe_n    = 1'b1;
                    dout_n  = DSACK_VAL;
                    tp_n    = 1'b1;
                end else if (cnt != 8'hFF) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            TERM: begin
                if (AS20) begin
                    state_n = IDLE;
                    sel_n   = 3'b000;
                    oe_n    = 1'b0;
                    dout_n  = 2'b11;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = 3'b000;
                oe_n    = 1'b0;
                dout_n  = 2'b11;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign REQ_RTC   = sel[2];
    assign REQ_BTN   = sel[1];
    assign REQ_JOY   = sel[0];
    assign DSACK_OUT = dout;
    assign DSACK_OE  = oe;
    assign BUSY      = busy;
    assign TIMEOUT_P = tp;

endmodule

// File: tb/tb_punt_cycle_sequencer.sv
// Bench for punt_cycle_sequencer: directed scenarios plus randomized
// punted cycles checked against an edge-timeline model.
module tb_punt_cycle_sequencer;

    localparam int         T  = 200;
    localparam logic [1:0] DV = 2'b10;

    logic       CLKCPU_A = 1'b0;
    logic       RESET = 1'b1, AS20 = 1'b1, PUNT_IN = 1'b0, ENABLE = 1'b0;
    logic       DEC_RTC = 1'b0, DEC_JOY = 1'b0, DEC_BTN = 1'b0, MCU_ACK = 1'b0;
    logic       REQ_RTC, REQ_JOY, REQ_BTN, DSACK_OE, BUSY, TIMEOUT_P;
    logic [1:0] DSACK_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    punt_cycle_sequencer #(.TIMEOUT(T), .DSACK_VAL(DV)) dut (
        .CLKCPU_A(CLKCPU_A), .RESET(RESET), .AS20(AS20), .PUNT_IN(PUNT_IN),
        .ENABLE(ENABLE), .DEC_RTC(DEC_RTC), .DEC_JOY(DEC_JOY), .DEC_BTN(DEC_BTN),
        .MCU_ACK(MCU_ACK), .REQ_RTC(REQ_RTC), .REQ_JOY(REQ_JOY), .REQ_BTN(REQ_BTN),
        .DSACK_OUT(DSACK_OUT), .DSACK_OE(DSACK_OE), .BUSY(BUSY), .TIMEOUT_P(TIMEOUT_P)
    );

    always #5 CLKCPU_A = ~CLKCPU_A;

    // Observed output bundle {REQ_RTC, REQ_BTN, REQ_JOY, DSACK_OUT, DSACK_OE, BUSY, TIMEOUT_P}.
    wire [7:0] obs = {REQ_RTC, REQ_BTN, REQ_JOY, DSACK_OUT, DSACK_OE, BUSY, TIMEOUT_P};

    // Expected bundle from the request select {rtc,btn,joy}, DSACK driven and timeout pulse.
    function automatic logic [7:0] ev(input logic [2:0] s, input logic drv, input logic tpl);
        return {s, drv ? DV : 2'b11, drv, |s, tpl};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge CLKCPU_A); #1; end
    endtask

    task automatic idle_inputs();
        AS20 = 1'b1; PUNT_IN = 1'b0; ENABLE = 1'b0; MCU_ACK = 1'b0;
        DEC_RTC = 1'b0; DEC_JOY = 1'b0; DEC_BTN = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1; MCU_ACK = 1'b1;
        step(2);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL reset: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        idle_inputs(); step(1); RESET = 1'b0; step(4);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, ev(3'b000, 0, 0)); end
    endtask

    task automatic test_rtc_read();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1; ENABLE = 1'b0;
        step(1);
        n_tests++; if (obs !== ev(3'b100, 0, 0)) begin n_fail++; $display("FAIL rtc_req: got %b expected %b", obs, ev(3'b100, 0, 0)); end
        step(4);
        MCU_ACK = 1'b1;
        step(2);
        n_tests++; if (obs !== ev(3'b100, 0, 0)) begin n_fail++; $display("FAIL rtc_ack_early: got %b expected %b", obs, ev(3'b100, 0, 0)); end
        step(1);
        n_tests++; if (obs !== ev(3'b100, 1, 0)) begin n_fail++; $display("FAIL rtc_term: got %b expected %b", obs, ev(3'b100, 1, 0)); end
        step(3);
        n_tests++; if (obs !== ev(3'b100, 1, 0)) begin n_fail++; $display("FAIL rtc_term_hold: got %b expected %b", obs, ev(3'b100, 1, 0)); end
        AS20 = 1'b1; MCU_ACK = 1'b0;
        step(1);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL rtc_release: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        idle_inputs(); step(4);
    endtask

    task automatic test_enable_gating();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_JOY = 1'b1; ENABLE = 1'b0;
        step(3);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL joy_gated: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        ENABLE = 1'b1;
        step(1);
        n_tests++; if (obs !== ev(3'b001, 0, 0)) begin n_fail++; $display("FAIL joy_enabled: got %b expected %b", obs, ev(3'b001, 0, 0)); end
        AS20 = 1'b1; step(1); idle_inputs(); step(4);
    endtask

    task automatic test_timeout();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_BTN = 1'b1; ENABLE = 1'b1;
        step(1);                    // entry edge E
        PUNT_IN = 1'b0; DEC_BTN = 1'b0; ENABLE = 1'b0;   // latched select must not care
        step(T - 1);                // edge E+T-1
        n_tests++; if (obs !== ev(3'b010, 0, 0)) begin n_fail++; $display("FAIL to_before: got %b expected %b", obs, ev(3'b010, 0, 0)); end
        step(1);                    // edge E+T
        n_tests++; if (obs !== ev(3'b010, 1, 1)) begin n_fail++; $display("FAIL to_fire: got %b expected %b", obs, ev(3'b010, 1, 1)); end
        step(1);
        n_tests++; if (obs !== ev(3'b010, 1, 0)) begin n_fail++; $display("FAIL to_pulse_end: got %b expected %b", obs, ev(3'b010, 1, 0)); end
        step(20);
        n_tests++; if (obs !== ev(3'b010, 1, 0)) begin n_fail++; $display("FAIL to_hold: got %b expected %b", obs, ev(3'b010, 1, 0)); end
        AS20 = 1'b1; step(1);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL to_release: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        idle_inputs(); step(4);
    endtask

    task automatic test_stale_ack();
        MCU_ACK = 1'b1; step(5);
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1;
        step(12);
        n_tests++; if (obs !== ev(3'b100, 0, 0)) begin n_fail++; $display("FAIL stale_ignored: got %b expected %b", obs, ev(3'b100, 0, 0)); end
        MCU_ACK = 1'b0; step(3);
        MCU_ACK = 1'b1; step(2);
        n_tests++; if (obs !== ev(3'b100, 0, 0)) begin n_fail++; $display("FAIL stale_reedge_early: got %b expected %b", obs, ev(3'b100, 0, 0)); end
        step(1);
        n_tests++; if (obs !== ev(3'b100, 1, 0)) begin n_fail++; $display("FAIL stale_reedge_term: got %b expected %b", obs, ev(3'b100, 1, 0)); end
        AS20 = 1'b1; MCU_ACK = 1'b0; step(1); idle_inputs(); step(4);
    endtask

    task automatic test_abort();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1;
        step(4);
        AS20 = 1'b1;
        step(1);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL abort: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        MCU_ACK = 1'b1; step(4);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL abort_no_dsack: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        idle_inputs(); step(4);
    endtask

    task automatic test_ack_on_timeout();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1;
        step(1);                    // entry edge E
        step(T - 3);
        MCU_ACK = 1'b1;             // first sampled at E+T-2, rise while cnt == T-1
        step(3);                    // edge E+T
        n_tests++; if (obs !== ev(3'b100, 1, 0)) begin n_fail++; $display("FAIL ack_vs_timeout: got %b expected %b", obs, ev(3'b100, 1, 0)); end
        step(1);
        n_tests++; if (obs !== ev(3'b100, 1, 0)) begin n_fail++; $display("FAIL ack_vs_timeout_next: got %b expected %b", obs, ev(3'b100, 1, 0)); end
        AS20 = 1'b1; MCU_ACK = 1'b0; step(1); idle_inputs(); step(4);
    endtask

    task automatic test_priority();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1; DEC_BTN = 1'b1; DEC_JOY = 1'b1; ENABLE = 1'b1;
        step(1);
        n_tests++; if (obs !== ev(3'b100, 0, 0)) begin n_fail++; $display("FAIL prio_rtc: got %b expected %b", obs, ev(3'b100, 0, 0)); end
        AS20 = 1'b1; step(1);
        AS20 = 1'b0; DEC_RTC = 1'b0;
        step(1);
        n_tests++; if (obs !== ev(3'b010, 0, 0)) begin n_fail++; $display("FAIL prio_btn: got %b expected %b", obs, ev(3'b010, 0, 0)); end
        AS20 = 1'b1; step(1); idle_inputs(); step(4);
    endtask

    task automatic test_reset_in_term();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1;
        step(2); MCU_ACK = 1'b1; step(3);
        n_tests++; if (obs !== ev(3'b100, 1, 0)) begin n_fail++; $display("FAIL rst_term_setup: got %b expected %b", obs, ev(3'b100, 1, 0)); end
        RESET = 1'b1;
        step(1);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL rst_in_term: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        RESET = 1'b0; DEC_RTC = 1'b0; MCU_ACK = 1'b0;
        step(3);
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL rst_stay_idle: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        DEC_RTC = 1'b1;
        step(1);
        n_tests++; if (obs !== ev(3'b100, 0, 0)) begin n_fail++; $display("FAIL rst_next_cycle: got %b expected %b", obs, ev(3'b100, 0, 0)); end
        AS20 = 1'b1; step(1); idle_inputs(); step(4);
    endtask

    task automatic test_back_to_back();
        AS20 = 1'b0; PUNT_IN = 1'b1; DEC_RTC = 1'b1;
        step(2); MCU_ACK = 1'b1; step(3);
        AS20 = 1'b1; MCU_ACK = 1'b0;
        step(1);                    // release edge K
        n_tests++; if (obs !== ev(3'b000, 0, 0)) begin n_fail++; $display("FAIL b2b_release: got %b expected %b", obs, ev(3'b000, 0, 0)); end
        AS20 = 1'b0; DEC_RTC = 1'b0; DEC_JOY = 1'b1; ENABLE = 1'b1;
        step(1);                    // edge K+1
        n_tests++; if (obs !== ev(3'b001, 0, 0)) begin n_fail++; $display("FAIL b2b_accept: got %b expected %b", obs, ev(3'b001, 0, 0)); end
        step(1); MCU_ACK = 1'b1; step(3);
        n_tests++; if (obs !== ev(3'b001, 1, 0)) begin n_fail++; $display("FAIL b2b_term: got %b expected %b", obs, ev(3'b001, 1, 0)); end
        AS20 = 1'b1; MCU_ACK = 1'b0; step(1); idle_inputs(); step(4);
    endtask

    // Random punted cycles. Edge 1 is the first edge sampling AS20 low; AS20 is
    // sampled high again at edge H+1. The model predicts the output timeline
    // from edge arithmetic: accept at 1, ack-driven DSACK at 3+a, forced DSACK
    // at 1+T, abort if AS20 rises no later than the termination edge.
    task automatic test_random();
        for (int trial = 0; trial < 40; trial++) begin
            logic       rtc, joy, btn, en, pt, has_ack, qual, to_win, term_ok;
            logic [2:0] s;
            int         h, a, term_e;
            logic [7:0] exp_v;
            rtc = 1'($urandom_range(0, 1)); joy = 1'($urandom_range(0, 1));
            btn = 1'($urandom_range(0, 1)); en  = 1'($urandom_range(0, 1));
            pt  = ($urandom_range(0, 7) != 0);
            has_ack = ($urandom_range(0, 3) != 0);
            h = (trial % 5 == 0) ? int'($urandom_range(195, 240)) : int'($urandom_range(2, 60));
            a = int'($urandom_range(1, (trial % 5 == 0) ? 220 : 50));
            qual = pt && (rtc || (en && (joy || btn)));
            s = rtc ? 3'b100 : ((en && btn) ? 3'b010 : ((en && joy) ? 3'b001 : 3'b000));
            to_win  = !(has_ack && (3 + a) <= (T + 1));
            term_e  = to_win ? (T + 1) : (3 + a);
            term_ok = qual && (term_e <= h);
            DEC_RTC = rtc; DEC_JOY = joy; DEC_BTN = btn; ENABLE = en; PUNT_IN = pt;
            for (int e = 1; e <= h + 2; e++) begin
                AS20    = (e <= h) ? 1'b0 : 1'b1;
                MCU_ACK = (has_ack && e >= 1 + a && e <= h) ? 1'b1 : 1'b0;
                if (qual && e >= 2) begin
                    DEC_RTC = 1'($urandom_range(0, 1)); DEC_JOY = 1'($urandom_range(0, 1));
                    DEC_BTN = 1'($urandom_range(0, 1)); ENABLE  = 1'($urandom_range(0, 1));
                    PUNT_IN = 1'($urandom_range(0, 1));
                end
                step(1);
                if (!qual || e > h) exp_v = ev(3'b000, 0, 0);
                else exp_v = ev(s, term_ok && e >= term_e, term_ok && to_win && e == term_e);
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL random t%0d edge %0d: got %b expected %b", trial, e, obs, exp_v);
                end
            end
            idle_inputs(); step(4);
        end
    endtask

    initial begin
        idle_inputs();
        RESET = 1'b1;
        test_reset();
        test_rtc_read();
        test_enable_gating();
        test_timeout();
        test_stale_ack();
        test_abort();
        test_ack_on_timeout();
        test_priority();
        test_reset_in_term();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
